// File: rtl/pattern_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pattern_scan_arbiter
// Purpose  : Shares one serial Moore pattern detector among N_REQ requesters.
//            A round-robin arbiter grants one requester's DATA_W-bit word.
//            The word is then shifted MSB-first into the detector after a
//            one-cycle detector clear. The detector output is sampled once
//            per bit. The per-bit hit mask and the hit count are returned on
//            a valid/ready response channel.
// Ports    : clk, rst (sync, active-low)
//            req_valid/req_data/req_ready : requester side, one-hot accept
//            det_w/det_rst_n/det_z        : external detector interface
//            resp_valid/resp_id/resp_hit_mask/resp_hits/resp_ready : result
// Revision : 1.0 - initial release
// ============================================================================
module pattern_scan_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       det_w,
  output logic                       det_rst_n,
  input  logic                       det_z,
  output logic                       resp_valid,
  output logic [$clog2(N_REQ)-1:0]   resp_id,
  output logic [DATA_W-1:0]          resp_hit_mask,
  output logic [CNT_W-1:0]           resp_hits,
  input  logic                       resp_ready
);

  localparam int C_ID_W = $clog2(N_REQ);
  localparam int C_BC_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [C_ID_W-1:0]   r_rr_ptr;
  logic [DATA_W-1:0]   r_shift;
  logic [C_BC_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]   r_mask;
  logic [CNT_W-1:0]    r_hits;
  logic                r_resp_valid;
  logic [C_ID_W-1:0]   r_resp_id;

  logic [C_ID_W:0]     w_idx;
  logic                w_gnt_found;
  logic [C_ID_W-1:0]   w_gnt_id;
  logic [DATA_W-1:0]   w_gnt_word;
  logic                w_accept;
  logic [C_ID_W-1:0]   w_rr_nxt;

  // --------------------------------------------------------------------------
  // Round-robin search starting at r_rr_ptr. Walking the offsets from the
  // highest down lets the smallest offset with a valid request win last.
  // The index is one bit wider so rr_ptr+offset can be folded mod N_REQ.
  // --------------------------------------------------------------------------
  always_comb begin
    w_idx       = '0;
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_rr_ptr} + (C_ID_W + 1)'(i);
      if (w_idx >= (C_ID_W + 1)'(N_REQ)) begin
        w_idx = w_idx - (C_ID_W + 1)'(N_REQ);
      end
      if (req_valid[w_idx[C_ID_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = w_idx[C_ID_W-1:0];
      end
    end
  end

  assign w_gnt_word = req_data[int'(w_gnt_id) * DATA_W +: DATA_W];

  // Accept is suppressed while reset is asserted so no strobe leaks out.
  assign w_accept  = (r_state == S_IDLE) && w_gnt_found && rst;
  assign req_ready = w_accept ? ({{(N_REQ - 1){1'b0}}, 1'b1} << w_gnt_id) : '0;

  assign w_rr_nxt  = (r_resp_id == C_ID_W'(N_REQ - 1)) ? '0 : (r_resp_id + C_ID_W'(1));

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and detector drive
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    det_w       = 1'b0;
    // The detector is held in clear during reset and for the CLEAR cycle.
    det_rst_n   = rst && (r_state != S_CLEAR);
    case (r_state)
      S_IDLE: begin
        if (w_gnt_found) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        det_w = r_shift[DATA_W-1];
        if (r_bit_cnt == C_BC_W'(DATA_W - 1)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath. det_z is a registered Moore output, so in SHIFT cycle k it
  // reflects the bit driven in cycle k-1. The mask is built by shifting the
  // sampled z in from the LSB: the first recorded sample (bit DATA_W-1 of
  // the word) ends up in the MSB after DATA_W samples, the DRAIN sample in
  // bit 0. SHIFT cycle 0 is skipped because the detector was just cleared.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr     <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_mask       <= '0;
      r_hits       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            r_shift   <= w_gnt_word;
            r_resp_id <= w_gnt_id;
            r_mask    <= '0;
            r_hits    <= '0;
          end
        end
        S_CLEAR: begin
          r_bit_cnt <= '0;
        end
        S_SHIFT: begin
          r_shift   <= r_shift << 1;
          r_bit_cnt <= r_bit_cnt + C_BC_W'(1);
          if (r_bit_cnt != '0) begin
            r_mask <= {r_mask[DATA_W-2:0], det_z};
            r_hits <= r_hits + CNT_W'(det_z);
          end
        end
        S_DRAIN: begin
          r_mask       <= {r_mask[DATA_W-2:0], det_z};
          r_hits       <= r_hits + CNT_W'(det_z);
          r_resp_valid <= 1'b1;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rr_ptr     <= w_rr_nxt;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_id       = r_resp_id;
  assign resp_hit_mask = r_mask;
  assign resp_hits     = r_hits;

endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pattern_scan_arbiter
// Purpose  : Self-checking bench for pattern_scan_arbiter. Includes a
//            behavioural Moore detector (z=1 after the last three bits were
//            110 or 101). A scoreboard queue holds expected responses pushed
//            on each grant; a monitor pops them on every response handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_scan_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    det_w;
  logic                    det_rst_n;
  logic                    det_z;
  logic                    resp_valid;
  logic [1:0]              resp_id;
  logic [DATA_W-1:0]       resp_hit_mask;
  logic [CNT_W-1:0]        resp_hits;
  logic                    resp_ready;

  always #5 clk = ~clk;

  pattern_scan_arbiter #(
    .N_REQ (N_REQ),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .det_w        (det_w),
    .det_rst_n    (det_rst_n),
    .det_z        (det_z),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_hit_mask(resp_hit_mask),
    .resp_hits    (resp_hits),
    .resp_ready   (resp_ready)
  );

  // Detector: registered bit history, sync active-low clear.
  logic [2:0] hist;
  always @(posedge clk) begin
    if (!det_rst_n) hist <= 3'b000;
    else            hist <= {hist[1:0], det_w};
  end
  assign det_z = (hist == 3'b110) || (hist == 3'b101);

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] mask;
    logic [3:0] hits;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t rst_e;
  int   checks = 0;
  int   errors = 0;
  bit   got_g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops one expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got response id %0d, expected none", resp_id);
      end else begin
        mon_e = sb.pop_front();
        check("resp_id",   32'(resp_id),       32'(mon_e.id));
        check("resp_mask", 32'(resp_hit_mask), 32'(mon_e.mask));
        check("resp_hits", 32'(resp_hits),     32'(mon_e.hits));
      end
    end
  end

  // One scan: wait for grant, check clear/shift timing, latency and optional
  // response stall. Starts and ends just after a rising edge.
  task automatic scan(input int id, input logic [7:0] word, input logic [7:0] mask,
                      input logic [3:0] hits, input int stall, input bit keep);
    exp_t e;
    bit   got;
    got    = 1'b0;
    e.id   = 2'(id);
    e.mask = mask;
    e.hits = hits;
    resp_ready = (stall == 0);
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      got = (req_ready != '0);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no req_ready, expected grant to %0d", id);
      return;
    end
    check("grant",           32'(req_ready),  32'(1) << id);
    check("idle_resp_valid", 32'(resp_valid), 32'(0));
    sb.push_back(e);
    @(posedge clk); #1;
    if (!keep) req_valid[id] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("busy_req_ready", 32'(req_ready), 32'(0));
      check("det_rst_n",      32'(det_rst_n), (c == 1) ? 32'(0) : 32'(1));
      if (c >= 2 && c <= 9) check("det_w", 32'(det_w), 32'(word[9-c]));
      if (c == 10) check("early_resp_valid", 32'(resp_valid), 32'(0));
    end
    @(negedge clk);
    check("resp_latency", 32'(resp_valid), 32'(1));
    for (int s = 0; s < stall; s++) begin
      if (s > 0) @(negedge clk);
      check("stall_valid",     32'(resp_valid),    32'(1));
      check("stall_id",        32'(resp_id),       32'(e.id));
      check("stall_mask",      32'(resp_hit_mask), 32'(e.mask));
      check("stall_hits",      32'(resp_hits),     32'(e.hits));
      check("stall_req_ready", 32'(req_ready),     32'(0));
    end
    if (stall > 0) begin
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      check("release_req_ready", 32'(req_ready), 32'(0));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  32'(req_ready),     32'(0));
    check("rst_resp_valid", 32'(resp_valid),    32'(0));
    check("rst_resp_id",    32'(resp_id),       32'(0));
    check("rst_mask",       32'(resp_hit_mask), 32'(0));
    check("rst_hits",       32'(resp_hits),     32'(0));
    check("rst_det_w",      32'(det_w),         32'(0));
    check("rst_det_rst_n",  32'(det_rst_n),     32'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_no_req_ready", 32'(req_ready), 32'(0));
    check("idle_det_rst_n",    32'(det_rst_n), 32'(1));
    @(posedge clk); #1;

    // Single-requester scans, several words.
    req_data[7:0]   = 8'hD0; req_valid = 4'b0001;
    scan(0, 8'hD0, 8'h30, 4'd2, 0, 1'b0);
    req_data[15:8]  = 8'hB6; req_valid = 4'b0010;
    scan(1, 8'hB6, 8'h2D, 4'd4, 0, 1'b0);
    req_data[31:24] = 8'h00; req_valid = 4'b1000;
    scan(3, 8'h00, 8'h00, 4'd0, 0, 1'b0);
    req_data[15:8]  = 8'hFF; req_valid = 4'b0010;
    scan(1, 8'hFF, 8'h00, 4'd0, 0, 1'b0);

    // Response stall of 5 cycles with the requester still asking.
    req_data[23:16] = 8'hD0; req_valid = 4'b0100;
    scan(2, 8'hD0, 8'h30, 4'd2, 5, 1'b1);
    req_valid = '0;

    // Reset, then round-robin between req0 and req2.
    req_data  = {8'h00, 8'hB6, 8'h00, 8'hD0};
    req_valid = 4'b0101;
    rst = 1'b0;
    @(negedge clk);
    check("rst2_det_rst_n",  32'(det_rst_n),  32'(0));
    check("rst2_req_ready",  32'(req_ready),  32'(0));
    check("rst2_resp_valid", 32'(resp_valid), 32'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    scan(0, 8'hD0, 8'h30, 4'd2, 0, 1'b1);
    scan(2, 8'hB6, 8'h2D, 4'd4, 0, 1'b1);
    scan(0, 8'hD0, 8'h30, 4'd2, 0, 1'b1);
    scan(2, 8'hB6, 8'h2D, 4'd4, 0, 1'b1);
    req_valid = 4'b0010; req_data[15:8] = 8'h6A;
    scan(1, 8'h6A, 8'h1A, 4'd3, 0, 1'b0);

    // Reset during SHIFT bit 4; the request must be re-granted afterwards.
    req_data[7:0] = 8'hB6; req_valid = 4'b0001;
    got_g = 1'b0;
    for (int t = 0; t < 40 && !got_g; t++) begin
      @(negedge clk);
      got_g = (req_ready != '0);
    end
    check("rstscan_grant", 32'(req_ready), 32'(4'b0001));
    rst_e.id = 2'd0; rst_e.mask = 8'h2D; rst_e.hits = 4'd4;
    sb.push_back(rst_e);
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    check("midrst_det_rst_n", 32'(det_rst_n), 32'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    scan(0, 8'hB6, 8'h2D, 4'd4, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
